// File: rtl/amiga_daug_pkg.sv
// Shared types and constants for the Amiga daughterboard DRAM controller.
// Holds the FSM state enum, default timing values and _CAS bit positions.
package amiga_daug_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROW,
      ST_COL,
      ST_ACK,
      ST_PRE,
      ST_REF_CAS,
      ST_REF_RAS
   } state_t;

   localparam int REFRESH_DIV_DEF    = 112;
   localparam int CAS_CYCLES_DEF     = 2;
   localparam int PRE_CYCLES_DEF     = 2;
   localparam int REF_RAS_CYCLES_DEF = 3;

   // _CAS bit positions: {bank1 upper, bank1 lower, bank0 upper, bank0 lower}
   localparam int CAS_B0L = 0;
   localparam int CAS_B0U = 1;
   localparam int CAS_B1L = 2;
   localparam int CAS_B1U = 3;

   // Active-low column strobes for one bank, gated by the CPU data strobes.
   function automatic logic [3:0] cas_sel(
      input logic bank,
      input logic uds_n,
      input logic lds_n
   );
      logic [3:0] c;
      c = 4'hF;
      if (bank) begin
         c[CAS_B1U] = uds_n;
         c[CAS_B1L] = lds_n;
      end else begin
         c[CAS_B0U] = uds_n;
         c[CAS_B0L] = lds_n;
      end
      return c;
   endfunction

endpackage

// File: rtl/amiga_daug_ram_ctrl_ref_timer.sv
// Refresh divider with pending flag and sticky missed-refresh flag.
// Ports: CLK, RST (async high), ACK (clear pending), PEND, MISS.
module amiga_daug_ref_timer
   import amiga_daug_pkg::*;
#(
   parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
   input  logic CLK,
   input  logic RST,
   input  logic ACK,
   output logic PEND,
   output logic MISS
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          tick;
   logic          pend_q;
   logic          miss_q;

   assign tick = (cnt == CW'(REFRESH_DIV - 1));

   // The wrap tick is visible in the same clock so a refresh wins over
   // a CPU cycle that starts together with it.
   assign PEND = pend_q | tick;
   assign MISS = miss_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt    <= '0;
         pend_q <= 1'b0;
         miss_q <= 1'b0;
      end else begin
         cnt    <= tick ? '0 : cnt + CW'(1);
         pend_q <= (pend_q | tick) & ~ACK;
         // A new tick while one is still outstanding loses a refresh.
         if (tick && pend_q)
            miss_q <= 1'b1;
      end
   end

endmodule

// File: rtl/amiga_daug_ram_ctrl.sv
// DRAM controller for the Amiga daughterboard RAM: CPU access FSM with
// CAS-before-RAS refresh and a write-protect latch. All outputs registered.
// Ports: CLK, RST, SEL, _AS, _UDS, _LDS, _PRW, A[17:1], LOCK_REQ in;
// MA, _RAS, _CAS[3:0], _WE, _DTACK, _WPRO, REF_MISS out.
module amiga_daug_ram_ctrl
   import amiga_daug_pkg::*;
#(
   parameter int REFRESH_DIV    = REFRESH_DIV_DEF,
   parameter int CAS_CYCLES     = CAS_CYCLES_DEF,
   parameter int PRE_CYCLES     = PRE_CYCLES_DEF,
   parameter int REF_RAS_CYCLES = REF_RAS_CYCLES_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        SEL,
   input  logic        _AS,
   input  logic        _UDS,
   input  logic        _LDS,
   input  logic        _PRW,
   input  logic [17:1] A,
   input  logic        LOCK_REQ,
   output logic [7:0]  MA,
   output logic        _RAS,
   output logic [3:0]  _CAS,
   output logic        _WE,
   output logic        _DTACK,
   output logic        _WPRO,
   output logic        REF_MISS
);

   state_t     state, state_n;
   logic [7:0] cnt, cnt_n;

   logic       ras_q, ras_n;
   logic [3:0] cas_q, cas_n;
   logic       we_q, we_n;
   logic       dtack_q, dtack_n;
   logic [7:0] ma_q, ma_n;
   logic       lock_q;

   logic       ref_pend;
   logic       ref_ack;
   logic       to_pre;

   amiga_daug_ref_timer #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_ref (
      .CLK  (CLK),
      .RST  (RST),
      .ACK  (ref_ack),
      .PEND (ref_pend),
      .MISS (REF_MISS)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         ras_q   <= 1'b1;
         cas_q   <= 4'hF;
         we_q    <= 1'b1;
         dtack_q <= 1'b1;
         ma_q    <= '0;
         lock_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         ras_q   <= ras_n;
         cas_q   <= cas_n;
         we_q    <= we_n;
         dtack_q <= dtack_n;
         ma_q    <= ma_n;
         if (LOCK_REQ)
            lock_q <= 1'b1;
      end
   end

   // Output registers take the value belonging to the state being entered.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ras_n   = ras_q;
      cas_n   = cas_q;
      we_n    = we_q;
      dtack_n = dtack_q;
      ma_n    = ma_q;
      ref_ack = 1'b0;
      to_pre  = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (ref_pend) begin
               state_n = ST_REF_CAS;
               ref_ack = 1'b1;
               ras_n   = 1'b1;
               cas_n   = 4'h0;
               we_n    = 1'b1;
               dtack_n = 1'b1;
            end else if (SEL && !_AS) begin
               state_n = ST_ROW;
               ras_n   = 1'b0;
               cas_n   = 4'hF;
               we_n    = 1'b1;
               dtack_n = 1'b1;
               ma_n    = A[8:1];
            end
         end

         ST_ROW: begin
            if (_AS) begin
               to_pre = 1'b1;
            end else begin
               state_n = ST_COL;
               cnt_n   = '0;
               ma_n    = A[16:9];
               // Strobes are fixed here for the whole column phase, so a
               // lock arriving mid-write cannot cut it short.
               if (!_PRW && lock_q) begin
                  cas_n = 4'hF;
                  we_n  = 1'b1;
               end else begin
                  cas_n = cas_sel(A[17], _UDS, _LDS);
                  we_n  = _PRW;
               end
            end
         end

         ST_COL: begin
            if (_AS) begin
               to_pre = 1'b1;
            end else if (cnt == 8'(CAS_CYCLES - 1)) begin
               state_n = ST_ACK;
               dtack_n = 1'b0;
               // Data already latched on the CAS fall.
               we_n    = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end

         ST_ACK: begin
            if (_AS)
               to_pre = 1'b1;
         end

         ST_PRE: begin
            if (cnt == 8'(PRE_CYCLES - 1))
               state_n = ST_IDLE;
            else
               cnt_n = cnt + 8'd1;
         end

         ST_REF_CAS: begin
            state_n = ST_REF_RAS;
            cnt_n   = '0;
            ras_n   = 1'b0;
            cas_n   = 4'h0;
         end

         ST_REF_RAS: begin
            if (cnt == 8'(REF_RAS_CYCLES - 1))
               to_pre = 1'b1;
            else
               cnt_n = cnt + 8'd1;
         end

         default: begin
            to_pre = 1'b1;
         end
      endcase

      if (to_pre) begin
         state_n = ST_PRE;
         cnt_n   = '0;
         ras_n   = 1'b1;
         cas_n   = 4'hF;
         we_n    = 1'b1;
         dtack_n = 1'b1;
      end
   end

   assign MA     = ma_q;
   assign _RAS   = ras_q;
   assign _CAS   = cas_q;
   assign _WE    = we_q;
   assign _DTACK = dtack_q;
   assign _WPRO  = ~lock_q;

endmodule

// File: tb/tb_amiga_daug_ram_ctrl.sv
// Directed self-checking bench for amiga_daug_ram_ctrl.
// Strobe vector under check is {_RAS, _CAS[3:0], _WE, _DTACK}.
module tb_amiga_daug_ram_ctrl;

   localparam int DIV = 112;

   logic        clk;
   logic        rst;
   logic        sel;
   logic        as_n;
   logic        uds_n;
   logic        lds_n;
   logic        prw;
   logic [17:1] a;
   logic        lock_req;
   logic [7:0]  ma;
   logic        ras_n;
   logic [3:0]  cas_n;
   logic        we_n;
   logic        dtack_n;
   logic        wpro_n;
   logic        ref_miss;
   logic [6:0]  strobe;

   int errs   = 0;
   int checks = 0;

   // Expected strobe patterns
   localparam logic [6:0] S_IDLE  = 7'b1_1111_1_1;
   localparam logic [6:0] S_ROW   = 7'b0_1111_1_1;
   localparam logic [6:0] S_RDCOL = 7'b0_0011_1_1;
   localparam logic [6:0] S_RDACK = 7'b0_0011_1_0;
   localparam logic [6:0] S_WRCOL = 7'b0_1110_0_1;
   localparam logic [6:0] S_WRACK = 7'b0_1110_1_0;
   localparam logic [6:0] S_LKACK = 7'b0_1111_1_0;
   localparam logic [6:0] S_RFCAS = 7'b1_0000_1_1;
   localparam logic [6:0] S_RFRAS = 7'b0_0000_1_1;

   assign strobe = {ras_n, cas_n, we_n, dtack_n};

   amiga_daug_ram_ctrl #(
      .REFRESH_DIV    (DIV),
      .CAS_CYCLES     (2),
      .PRE_CYCLES     (2),
      .REF_RAS_CYCLES (3)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .SEL      (sel),
      ._AS      (as_n),
      ._UDS     (uds_n),
      ._LDS     (lds_n),
      ._PRW     (prw),
      .A        (a),
      .LOCK_REQ (lock_req),
      .MA       (ma),
      ._RAS     (ras_n),
      ._CAS     (cas_n),
      ._WE      (we_n),
      ._DTACK   (dtack_n),
      ._WPRO    (wpro_n),
      .REF_MISS (ref_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_idle();
      sel      = 1'b0;
      as_n     = 1'b1;
      uds_n    = 1'b1;
      lds_n    = 1'b1;
      prw      = 1'b1;
      a        = '0;
      lock_req = 1'b0;
   endtask

   // Leaves the bench at the negedge of reset release (N0).
   task automatic do_reset();
      bus_idle();
      rst = 1'b1;
      nclk(2);
      rst = 1'b0;
   endtask

   task automatic start_read();
      sel   = 1'b1;
      as_n  = 1'b0;
      uds_n = 1'b0;
      lds_n = 1'b0;
      prw   = 1'b1;
      a     = 17'h1_2345;
   endtask

   initial begin
      bus_idle();
      rst = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_strobe", strobe, S_IDLE);
      chk("rst_ma", ma, 8'h00);
      chk("rst_wpro", wpro_n, 1'b1);
      chk("rst_miss", ref_miss, 1'b0);
      nclk(2);
      rst = 1'b0;

      // Read from bank 1, both bytes
      do_reset();
      start_read();
      nclk(1);
      chk("rd_row", strobe, S_ROW);
      chk("rd_row_ma", ma, 8'h45);
      nclk(1);
      chk("rd_col1", strobe, S_RDCOL);
      chk("rd_col_ma", ma, 8'h23);
      nclk(1);
      chk("rd_col2", strobe, S_RDCOL);
      nclk(1);
      chk("rd_ack", strobe, S_RDACK);
      nclk(2);
      chk("rd_ack_hold", strobe, S_RDACK);
      as_n = 1'b1;
      nclk(1);
      chk("rd_pre1", strobe, S_IDLE);
      as_n = 1'b0;
      nclk(1);
      chk("rd_pre2", ras_n, 1'b1);
      nclk(1);
      chk("rd_idle", ras_n, 1'b1);
      nclk(1);
      chk("rd_reacc_row", strobe, S_ROW);
      // Abort from ROW
      as_n = 1'b1;
      nclk(1);
      chk("abort_row", strobe, S_IDLE);
      nclk(3);
      chk("abort_row_dtack", dtack_n, 1'b1);

      // Lower-byte write, lock arriving mid-COL
      do_reset();
      sel   = 1'b1;
      as_n  = 1'b0;
      uds_n = 1'b1;
      lds_n = 1'b0;
      prw   = 1'b0;
      a     = 17'h0_0100;
      nclk(1);
      chk("wr_row_ma", ma, 8'h00);
      nclk(1);
      chk("wr_col1", strobe, S_WRCOL);
      chk("wr_col_ma", ma, 8'h01);
      lock_req = 1'b1;
      nclk(1);
      lock_req = 1'b0;
      chk("wr_col2_lockmid", strobe, S_WRCOL);
      chk("wpro_set", wpro_n, 1'b0);
      nclk(1);
      chk("wr_ack", strobe, S_WRACK);
      as_n = 1'b1;
      nclk(4);

      // Same write while locked
      as_n = 1'b0;
      nclk(1);
      chk("lk_row", strobe, S_ROW);
      nclk(1);
      chk("lk_col1", strobe, S_ROW);
      nclk(1);
      chk("lk_col2", strobe, S_ROW);
      nclk(1);
      chk("lk_ack", strobe, S_LKACK);
      chk("lk_wpro", wpro_n, 1'b0);
      as_n = 1'b1;
      nclk(4);

      // Refresh tick coincides with _AS fall
      do_reset();
      nclk(DIV - 1);
      start_read();
      nclk(1);
      chk("ref_cas", strobe, S_RFCAS);
      nclk(1);
      chk("ref_ras1", strobe, S_RFRAS);
      nclk(2);
      chk("ref_ras3", strobe, S_RFRAS);
      nclk(1);
      chk("ref_pre", strobe, S_IDLE);
      nclk(2);
      chk("ref_idle", strobe, S_IDLE);
      nclk(1);
      chk("ref_then_row", strobe, S_ROW);
      nclk(3);
      chk("ref_then_ack", strobe, S_RDACK);
      chk("ref_nomiss", ref_miss, 1'b0);
      as_n = 1'b1;
      nclk(4);

      // Refresh starved by a held access
      do_reset();
      start_read();
      nclk(2 * DIV - 1);
      chk("miss_before", ref_miss, 1'b0);
      nclk(1);
      chk("miss_set", ref_miss, 1'b1);
      chk("miss_dtack", dtack_n, 1'b0);
      as_n = 1'b1;
      nclk(20);
      chk("miss_sticky", ref_miss, 1'b1);

      // Reset during COL
      do_reset();
      lock_req = 1'b1;
      nclk(1);
      lock_req = 1'b0;
      chk("rc_lock", wpro_n, 1'b0);
      start_read();
      nclk(2);
      chk("rc_col", strobe, S_RDCOL);
      #2 rst = 1'b1;
      #1;
      chk("rc_strobe", strobe, S_IDLE);
      chk("rc_wpro", wpro_n, 1'b1);
      chk("rc_ma", ma, 8'h00);
      nclk(1);
      rst = 1'b0;
      nclk(1);
      chk("rc_first_row", strobe, S_ROW);
      as_n = 1'b1;
      nclk(4);

      // SEL low is ignored, then abort from COL
      do_reset();
      start_read();
      sel = 1'b0;
      nclk(2);
      chk("nosel_a", strobe, S_IDLE);
      nclk(3);
      chk("nosel_b", strobe, S_IDLE);
      sel = 1'b1;
      nclk(2);
      chk("ab_col", strobe, S_RDCOL);
      as_n = 1'b1;
      nclk(1);
      chk("ab_pre", strobe, S_IDLE);
      nclk(1);
      chk("ab_nodtack", dtack_n, 1'b1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/amiga_daug_ram_ctrl.md
AMIGA_DAUG_RAM_CTRL -- requirements
Module: amiga_daug_ram_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 112, is the number of clocks between refresh requests (15.6 us at 7.16 MHz).
REQ-002 Parameter CAS_CYCLES, default 2, is the number of clocks CAS is held in a CPU access.
REQ-003 Parameter PRE_CYCLES, default 2, is the number of RAS precharge clocks after any cycle.
REQ-004 Parameter REF_RAS_CYCLES, default 3, is the number of RAS-low clocks in a refresh.
REQ-005 Ports (name, direction, width, meaning):
- CLK, in, 1: sole clock.
- RST, in, 1: reset, asynchronous and active-high.
- SEL, in, 1: address decode hit for the daughterboard RAM.
- _AS, in, 1: CPU address strobe.
- _UDS, in, 1: CPU upper data strobe.
- _LDS, in, 1: CPU lower data strobe.
- _PRW, in, 1: 1 = read, 0 = write.
- A, in, 17: A[17:1]; A[17] selects the bank, A[16:1] is the word address.
- LOCK_REQ, in, 1: one-clock pulse that sets write protect.
- MA, out, 8: DRAM multiplexed address.
- _RAS, out, 1: row strobe.
- _CAS, out, 4: column strobes {bank1 upper, bank1 lower, bank0 upper, bank0 lower}.
- _WE, out, 1: DRAM write enable.
- _DTACK, out, 1: CPU acknowledge.
- _WPRO, out, 1: low while write protect is set; drives the LED.
- REF_MISS, out, 1: sticky flag set when a refresh tick is lost.

Function
REQ-006 The state machine SHALL have states IDLE, ROW, COL, ACK, PRE, REF_CAS, REF_RAS, and all outputs SHALL be registered.
REQ-007 In IDLE with a refresh pending, the next state SHALL be REF_CAS; refresh takes priority over a CPU access starting in the same clock.
REQ-008 In IDLE with no refresh pending and SEL=1 and _AS=0, the next state SHALL be ROW.
REQ-009 ROW SHALL last 1 clock with _RAS=0 and MA=A[8:1]; the state then moves to COL.
REQ-010 COL SHALL last CAS_CYCLES clocks:
- MA=A[16:9].
- The _CAS bits are selected by A[17] and gated by _UDS/_LDS.
- _WE=_PRW.
- The state then moves to ACK.
REQ-011 A write while locked SHALL keep _WE=1 and all _CAS=1 through COL, and SHALL still proceed to ACK.
REQ-012 ACK SHALL hold _DTACK=0, with _RAS and _CAS unchanged from COL, until _AS=1; the state then moves to PRE.
REQ-013 _AS=1 during ROW or COL SHALL abort to PRE with _DTACK never asserted.
REQ-014 PRE SHALL drive all strobes and _DTACK high for PRE_CYCLES clocks, then return to IDLE.
REQ-015 REF_CAS SHALL drive all four _CAS=0 for 1 clock (CAS-before-RAS), with _RAS=1 and _WE=1; the state then moves to REF_RAS.
REQ-016 REF_RAS SHALL drive _RAS=0 with _CAS=0 for REF_RAS_CYCLES clocks, then move to PRE.
REQ-017 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap, setting the pending flag on wrap.
REQ-018 The pending flag SHALL clear on entry to REF_CAS.
REQ-019 A wrap while the pending flag is already set SHALL set REF_MISS, which stays set until reset.
REQ-020 LOCK_REQ=1 SHALL set lock on the next edge; only RST clears it, and _WPRO = NOT lock.
REQ-021 A LOCK_REQ arriving during COL of a write SHALL NOT affect that cycle; _WE is sampled at COL entry.
REQ-022 SEL=0 with _AS=0 SHALL leave the block in IDLE with no strobe activity.

Reset
REQ-023 While RST=1, the block SHALL immediately force:
- state IDLE.
- _RAS=1, _CAS=4'hF, _WE=1, _DTACK=1.
- MA=0.
- refresh counter 0 and pending flag 0.
- lock 0 (_WPRO=1) and REF_MISS=0.
REQ-024 Reset asserted mid-access SHALL abort the access; the first state after release SHALL be IDLE.

Structure
REQ-025 A shared package amiga_daug_pkg SHALL hold:
- the state enum.
- the default parameter values.
- the _CAS bit index constants.
REQ-026 The refresh divider, pending flag and REF_MISS SHALL be one sub-module, amiga_daug_ref_timer, with ports CLK, RST, ACK (pending clear), PEND and MISS.

Verification
REQ-027 Read A=17'h1_2345, _UDS=_LDS=0, _PRW=1 -> checks:
- MA=8'h45 in ROW, then 8'h23 in COL.
- _CAS=4'b0011.
- _DTACK low 3 clocks after ROW entry, held until _AS rises.
- 2 precharge clocks follow.
REQ-028 Lower-byte write to A=17'h0_0100 with _LDS=0, _UDS=1 -> _CAS=4'b1110 and _WE=0 for 2 clocks.
REQ-029 LOCK_REQ pulse, then the same write -> _WPRO=0, _WE and _CAS stay high, _DTACK still asserted.
REQ-030 Refresh wrap coincides with an _AS fall -> the REF_CAS/REF_RAS sequence runs first, then the CPU access is served.
REQ-031 _AS held low for 2*REFRESH_DIV clocks -> REF_MISS=1.
REQ-032 RST pulse during COL -> all strobes high within the same clock and lock cleared.
